reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Parametrised multi-port register file. Successor to the 8×8 two-read/one-write file: configurable width and depth, two write ports with fixed priority, two registered read ports with valid flags, an optional hard-wired zero entry and a sequential clear sweep. It sits between the datapath write-back stage and the operand-fetch stage.

## Interface
Parameters:
- DATA_W, 8, entry width in bits (≥1)
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries (ADDR_W ≥1)
- ZERO_REG, 0, 1 = entry 0 always reads 0 and ignores writes

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- we0  in  1  write enable, port 0
- waddr0  in  ADDR_W  write address, port 0
- wdata0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (higher priority)
- waddr1  in  ADDR_W  write address, port 1
- wdata1  in  DATA_W  write data, port 1
- re1 / re2  in  1  read request, read ports 1/2
- raddr1 / raddr2  in  ADDR_W  read address, ports 1/2
- rdata1 / rdata2  out  DATA_W  registered read data
- rvalid1 / rvalid2  out  1  rdataN valid this cycle
- clr  in  1  single-cycle pulse: start clear sweep
- busy  out  1  clear sweep in progress

## Operation
- Reset (async): all DEPTH entries = 0, rdata1/2 = 0, rvalid1/2 = 0, busy = 0, FSM = IDLE, sweep pointer = 0.
- Write: on edge with weN=1, entry[waddrN] ← wdataN. Both ports may write in the same cycle.
- Write collision (we0=we1=1, waddr0==waddr1): port 1 wins, port 0 data is dropped.
- ZERO_REG=1: writes to address 0 are ignored; reads of address 0 return 0.
- Read: reN=1 at edge N → rdataN = entry[raddrN] and rvalidN = 1 after edge N (visible in cycle N+1). reN=0 → rvalidN = 0, rdataN holds its previous value.
- Both read ports are independent; both may read the same address.
- Clear FSM, states IDLE and SWEEP:
  - IDLE + clr=1 → SWEEP, pointer = 0, busy = 1 from the next cycle.
  - SWEEP: each cycle, entry[pointer] ← 0 and pointer++. After the entry at DEPTH−1 is cleared → IDLE, busy = 0, pointer = 0.
  - busy stays high for exactly DEPTH cycles.
  - clr while in SWEEP is ignored.
  - Writes on both ports are dropped while busy = 1.
  - Reads are serviced while busy = 1 and return current contents: already-cleared entries read 0.
- rst during SWEEP: aborts immediately; all entries 0, IDLE.

## Timing
- Write-to-storage: 1 edge. Read latency: 1 cycle (request at edge N, data at N+1).
- Read of an address written in the same cycle: see Configuration.
- No combinational path from any input to any output; all outputs are registered.
- Throughput: one read per port and up to two writes every cycle.

## Configuration
- REG_FILE_BYPASS_EN defined: a read and a write to the same address at the same edge return the new write data. If both write ports hit that address, the read returns the port-1 data. No bypass occurs for dropped writes (busy=1, or address 0 with ZERO_REG=1).
- Not defined: such a read returns the entry contents from before the write.

## Test plan
- Reset → read all 8 addresses on both ports: rdata=0x00, rvalid=1 one cycle after each re; with re=0, rvalid=0.
- we0: addr 3 ← 0xA5; next cycle re1 addr 3 → rdata1=0xA5 one cycle later; re2 addr 3 in the same cycle → rdata2=0xA5.
- Collision: we0 addr 5 ← 0x11 and we1 addr 5 ← 0x22 together; later read addr 5 → 0x22.
- Same-edge read and write at addr 2 (old 0x10, new 0x7E): with REG_FILE_BYPASS_EN, rdata1=0x7E; without it, rdata1=0x10.
- Fill all entries with 0xFF, pulse clr: busy=1 for exactly 8 cycles; a we1 addr 6 ← 0x33 mid-sweep is dropped; all entries read 0 afterwards. Repeat with rst asserted mid-sweep → immediately busy=0 and all entries 0.
- ZERO_REG=1: we0 addr 0 ← 0x5A, then read addr 0 → 0x00.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised register file with two prioritised write ports,
// two registered read ports with valid flags, an optional hard-wired zero
// entry (ZERO_REG) and a sequential clear sweep started by a clr pulse.
// Optional feature: define REG_FILE_BYPASS_EN to forward same-edge write data
// to a read of the same address. Without it, such a read returns the
// contents from before the write.
module reg_file_mp #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              rvalid1,
    output logic              rvalid2,
    input  logic              clr,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr0_ok;
    logic              wr1_ok;
    logic [DATA_W-1:0] rd1_next;
    logic [DATA_W-1:0] rd2_next;

    // A write takes effect only outside the sweep and never at the zero entry.
    always_comb begin
        wr0_ok = we0 && (state == IDLE) && !((ZERO_REG != 0) && (waddr0 == '0));
        wr1_ok = we1 && (state == IDLE) && !((ZERO_REG != 0) && (waddr1 == '0));
    end

    // Read data for the next edge: stored contents, optionally overridden by
    // same-edge write data (port 1 checked last so it wins a double hit).
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        rd1_next = mem[raddr1];
        rd2_next = mem[raddr2];
`ifdef REG_FILE_BYPASS_EN
        if (wr0_ok && (waddr0 == raddr1)) rd1_next = wdata0;
        if (wr1_ok && (waddr1 == raddr1)) rd1_next = wdata1;
        if (wr0_ok && (waddr0 == raddr2)) rd2_next = wdata0;
        if (wr1_ok && (waddr1 == raddr2)) rd2_next = wdata1;
`endif
        if ((ZERO_REG != 0) && (raddr1 == '0)) rd1_next = '0;
        if ((ZERO_REG != 0) && (raddr2 == '0)) rd2_next = '0;
    end

    // Storage and clear-sweep FSM: normal writes in IDLE, one entry zeroed
    // per cycle in SWEEP; busy is registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the storage array is reset here on purpose: reset must
            // leave every entry at zero, which rules out a plain RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            state <= IDLE;
            ptr   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // NOTE: non-blocking assignments for all state; the later
                    // port-1 assignment overrides port 0 on an address collision.
                    if (wr0_ok) mem[waddr0] <= wdata0;
                    if (wr1_ok) mem[waddr1] <= wdata1;
                    if (clr) begin
                        state <= SWEEP;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SWEEP: begin
                    mem[ptr] <= '0;
                    if (ptr == ADDR_W'(DEPTH - 1)) begin
                        state <= IDLE;
                        ptr   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ptr   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Registered read ports: data captured on request, held otherwise;
    // the valid flag follows the request by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata1  <= '0;
            rdata2  <= '0;
            rvalid1 <= 1'b0;
            rvalid2 <= 1'b0;
        end else begin
            rvalid1 <= re1;
            rvalid2 <= re2;
            if (re1) rdata1 <= rd1_next;
            if (re2) rdata2 <= rd2_next;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Testbench for reg_file_mp: two instances (ZERO_REG=0 and ZERO_REG=1) share
// one stimulus stream and are compared against an array-based reference model.
module tb_reg_file_mp;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          we0, we1, re1, re2, clr;
    logic [AW-1:0] waddr0, waddr1, raddr1, raddr2;
    logic [DW-1:0] wdata0, wdata1;

    logic [1:0][DW-1:0] rd1, rd2;
    logic [1:0]         rv1, rv2, bsy;

    int checks   = 0;
    int failures = 0;

    // Reference model: index 0 = plain instance, index 1 = zero-entry instance.
    logic [DW-1:0] mm   [2][DEPTH];
    bit            mbusy[2];
    int            midx [2];
    logic [DW-1:0] erd  [2][2];
    bit            erv  [2][2];

    always #5 clk = ~clk;

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) dut (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2),
        .rdata1(rd1[0]), .rdata2(rd2[0]), .rvalid1(rv1[0]), .rvalid2(rv2[0]),
        .clr(clr), .busy(bsy[0])
    );

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut_z (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2),
        .rdata1(rd1[1]), .rdata2(rd2[1]), .rvalid1(rv1[1]), .rvalid2(rv2[1]),
        .clr(clr), .busy(bsy[1])
    );

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < DEPTH; a++) mm[k][a] = '0;
            mbusy[k] = 1'b0;
            midx[k]  = 0;
            for (int p = 0; p < 2; p++) begin
                erd[k][p] = '0;
                erv[k][p] = 1'b0;
            end
        end
    endfunction

    // One clock edge of the specified behaviour, using the inputs as they
    // stand at that edge and the model contents from before it.
    function automatic void model_step();
        for (int k = 0; k < 2; k++) begin
            bit            ok0, ok1, r;
            logic [AW-1:0] ra;
            logic [DW-1:0] v;
            ok0 = we0 && !mbusy[k] && !((k == 1) && (waddr0 == 0));
            ok1 = we1 && !mbusy[k] && !((k == 1) && (waddr1 == 0));
            for (int p = 0; p < 2; p++) begin
                r  = (p == 0) ? re1 : re2;
                ra = (p == 0) ? raddr1 : raddr2;
                if (r) begin
                    v = mm[k][ra];
`ifdef REG_FILE_BYPASS_EN
                    if (ok1 && waddr1 == ra) v = wdata1;
                    else if (ok0 && waddr0 == ra) v = wdata0;
`endif
                    erd[k][p] = v;
                    erv[k][p] = 1'b1;
                end else begin
                    erv[k][p] = 1'b0;
                end
            end
            if (mbusy[k]) begin
                mm[k][midx[k]] = '0;
                midx[k]++;
                if (midx[k] == DEPTH) begin
                    mbusy[k] = 1'b0;
                    midx[k]  = 0;
                end
            end else begin
                if (ok0) mm[k][waddr0] = wdata0;
                if (ok1) mm[k][waddr1] = wdata1;
                if (clr) begin
                    mbusy[k] = 1'b1;
                    midx[k]  = 0;
                end
            end
        end
    endfunction

    task automatic idle();
        we0 = 0; we1 = 0; re1 = 0; re2 = 0; clr = 0;
        waddr0 = 0; waddr1 = 0; raddr1 = 0; raddr2 = 0;
        wdata0 = 0; wdata1 = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic fill(input logic [DW-1:0] val);
        for (int a = 0; a < DEPTH / 2; a++) begin
            idle();
            we0 = 1; waddr0 = AW'(2 * a);     wdata0 = val;
            we1 = 1; waddr1 = AW'(2 * a + 1); wdata1 = val;
            tick();
        end
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rd1[k] !== 8'h00 || rd2[k] !== 8'h00 || rv1[k] !== 1'b0 ||
                rv2[k] !== 1'b0 || bsy[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs inst=%0d got rd1=%h rd2=%h rv1=%b rv2=%b busy=%b exp all 0",
                         k, rd1[k], rd2[k], rv1[k], rv2[k], bsy[k]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            idle();
            re1 = 1; raddr1 = AW'(a);
            re2 = 1; raddr2 = AW'(DEPTH - 1 - a);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (rd1[k] !== 8'h00 || rv1[k] !== 1'b1 || rd2[k] !== 8'h00 || rv2[k] !== 1'b1) begin
                    failures++;
                    $display("FAIL reset_read addr=%0d inst=%0d got rd1=%h rv1=%b rd2=%h rv2=%b exp 00/1 00/1",
                             a, k, rd1[k], rv1[k], rd2[k], rv2[k]);
                end
            end
        end
        idle();
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rv1[k] !== 1'b0 || rv2[k] !== 1'b0) begin
                failures++;
                $display("FAIL no_request_valid inst=%0d got rv1=%b rv2=%b exp 0 0", k, rv1[k], rv2[k]);
            end
        end
    endtask

    task automatic test_write_read();
        idle();
        we0 = 1; waddr0 = 3; wdata0 = 8'hA5;
        tick();
        idle();
        re1 = 1; raddr1 = 3;
        re2 = 1; raddr2 = 3;
        tick();
        idle();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rd1[k] !== 8'hA5 || rv1[k] !== 1'b1 || rd2[k] !== 8'hA5 || rv2[k] !== 1'b1) begin
                failures++;
                $display("FAIL write_read inst=%0d got rd1=%h rv1=%b rd2=%h rv2=%b exp a5/1 a5/1",
                         k, rd1[k], rv1[k], rd2[k], rv2[k]);
            end
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rd1[k] !== 8'hA5 || rv1[k] !== 1'b0) begin
                failures++;
                $display("FAIL read_hold inst=%0d got rd1=%h rv1=%b exp a5/0", k, rd1[k], rv1[k]);
            end
        end
    endtask

    task automatic test_collision();
        idle();
        we0 = 1; waddr0 = 5; wdata0 = 8'h11;
        we1 = 1; waddr1 = 5; wdata1 = 8'h22;
        tick();
        idle();
        re1 = 1; raddr1 = 5;
        tick();
        idle();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rd1[k] !== 8'h22) begin
                failures++;
                $display("FAIL collision inst=%0d got=%h exp=22", k, rd1[k]);
            end
        end
    endtask

    task automatic test_same_edge();
        logic [DW-1:0] exp_v;
`ifdef REG_FILE_BYPASS_EN
        exp_v = 8'h7E;
`else
        exp_v = 8'h10;
`endif
        idle();
        we0 = 1; waddr0 = 2; wdata0 = 8'h10;
        tick();
        idle();
        we0 = 1; waddr0 = 2; wdata0 = 8'h7E;
        re1 = 1; raddr1 = 2;
        tick();
        idle();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rd1[k] !== exp_v) begin
                failures++;
                $display("FAIL same_edge inst=%0d got=%h exp=%h", k, rd1[k], exp_v);
            end
        end
        re1 = 1; raddr1 = 2;
        tick();
        idle();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rd1[k] !== 8'h7E) begin
                failures++;
                $display("FAIL same_edge_after inst=%0d got=%h exp=7e", k, rd1[k]);
            end
        end
    endtask

    task automatic test_sweep();
        int cnt;
        fill(8'hFF);
        clr = 1;
        tick();
        idle();
        cnt = 0;
        while (bsy[0] === 1'b1 && cnt < 20) begin
            cnt++;
            idle();
            re1 = 1; raddr1 = AW'($urandom_range(0, DEPTH - 1));
            re2 = 1; raddr2 = AW'($urandom_range(0, DEPTH - 1));
            if (cnt == 3) begin
                we1 = 1; waddr1 = 6; wdata1 = 8'h33;
            end
            if (cnt == 4) clr = 1;
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (rd1[k] !== erd[k][0] || rd2[k] !== erd[k][1] || rv1[k] !== erv[k][0] ||
                    rv2[k] !== erv[k][1] || bsy[k] !== mbusy[k]) begin
                    failures++;
                    $display("FAIL sweep_read cyc=%0d inst=%0d got rd1=%h rd2=%h rv=%b%b busy=%b exp rd1=%h rd2=%h rv=%b%b busy=%b",
                             cnt, k, rd1[k], rd2[k], rv1[k], rv2[k], bsy[k],
                             erd[k][0], erd[k][1], erv[k][0], erv[k][1], mbusy[k]);
                end
            end
        end
        idle();
        checks++;
        if (cnt != DEPTH || bsy[1] !== 1'b0) begin
            failures++;
            $display("FAIL busy_length got=%0d exp=%0d (busy_z=%b)", cnt, DEPTH, bsy[1]);
        end
        for (int a = 0; a < DEPTH; a++) begin
            idle();
            re1 = 1; raddr1 = AW'(a);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (rd1[k] !== 8'h00) begin
                    failures++;
                    $display("FAIL after_sweep addr=%0d inst=%0d got=%h exp=00", a, k, rd1[k]);
                end
            end
        end
        // Reset part-way through a second sweep.
        fill(8'hFF);
        clr = 1;
        tick();
        idle();
        repeat (3) tick();
        rst = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (bsy[k] !== 1'b0 || rv1[k] !== 1'b0 || rd1[k] !== 8'h00) begin
                failures++;
                $display("FAIL rst_mid_sweep inst=%0d got busy=%b rv1=%b rd1=%h exp 0 0 00",
                         k, bsy[k], rv1[k], rd1[k]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            idle();
            re2 = 1; raddr2 = AW'(a);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (rd2[k] !== 8'h00 || bsy[k] !== 1'b0) begin
                    failures++;
                    $display("FAIL after_rst_sweep addr=%0d inst=%0d got rd2=%h busy=%b exp 00 0",
                             a, k, rd2[k], bsy[k]);
                end
            end
        end
        idle();
    endtask

    task automatic test_zero_reg();
        idle();
        we0 = 1; waddr0 = 0; wdata0 = 8'h5A;
        tick();
        idle();
        re1 = 1; raddr1 = 0;
        re2 = 1; raddr2 = 0;
        tick();
        idle();
        checks++;
        if (rd1[1] !== 8'h00 || rd2[1] !== 8'h00) begin
            failures++;
            $display("FAIL zero_reg got rd1=%h rd2=%h exp 00 00", rd1[1], rd2[1]);
        end
        checks++;
        if (rd1[0] !== 8'h5A) begin
            failures++;
            $display("FAIL plain_addr0 got=%h exp=5a", rd1[0]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            we0    = 1'($urandom_range(0, 1));
            we1    = 1'($urandom_range(0, 1));
            re1    = 1'($urandom_range(0, 1));
            re2    = 1'($urandom_range(0, 1));
            clr    = ($urandom_range(0, 24) == 0);
            waddr0 = AW'($urandom_range(0, DEPTH - 1));
            waddr1 = AW'($urandom_range(0, DEPTH - 1));
            raddr1 = AW'($urandom_range(0, DEPTH - 1));
            raddr2 = AW'($urandom_range(0, DEPTH - 1));
            wdata0 = DW'($urandom);
            wdata1 = DW'($urandom);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (rd1[k] !== erd[k][0] || rd2[k] !== erd[k][1] || rv1[k] !== erv[k][0] ||
                    rv2[k] !== erv[k][1] || bsy[k] !== mbusy[k]) begin
                    failures++;
                    $display("FAIL random cyc=%0d inst=%0d got rd1=%h rd2=%h rv=%b%b busy=%b exp rd1=%h rd2=%h rv=%b%b busy=%b",
                             n, k, rd1[k], rd2[k], rv1[k], rv2[k], bsy[k],
                             erd[k][0], erd[k][1], erv[k][0], erv[k][1], mbusy[k]);
                end
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_collision();
        test_same_edge();
        test_zero_reg();
        test_sweep();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
